// File: rtl/pio_ram_emu_responder_if.sv
// Two-pin PIO RAM-emulator link as seen from both ends.
//   rx_pins     : request stream into the responder (idle 2'b11)
//   tx_pins     : response stream out of the responder (idle 2'b11)
//   frame_error : sticky, a request frame ended with a bad stop cycle
//   bad_header  : sticky, a request carried an undefined command
//   overrun     : sticky, a read response was dropped
// master = the design-side end, slave = the RAM responder.
interface pio_ram_emu_responder_if;
    logic [1:0] rx_pins;
    logic [1:0] tx_pins;
    logic       frame_error;
    logic       bad_header;
    logic       overrun;

    modport master (
        output rx_pins,
        input  tx_pins,
        input  frame_error,
        input  bad_header,
        input  overrun
    );

    modport slave (
        input  rx_pins,
        output tx_pins,
        output frame_error,
        output bad_header,
        output overrun
    );
endinterface

// File: rtl/pio_ram_emu_responder.sv
// RAM side of the 2-pin PIO RAM-emulator link.
// Deserializes request frames (start cycle + 11 two-bit payload cycles,
// payload = {2'b11, data[15:0], header[3:0]}, LSB first), executes
// SET_ADDR / WRITE / READ / READ_NEXT against a 16-bit memory, and
// serializes read responses (start 2'b10, two 2'b11 fillers, 8 payload
// cycles LSB first) back on tx_pins.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset (memory contents are kept)
//   link  : slave end of the link interface (rx/tx pins and sticky flags)
module pio_ram_emu_responder #(
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned RESPONSE_DELAY = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    pio_ram_emu_responder_if.slave link
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    localparam logic [3:0] CMD_SET_ADDR  = 4'h0;
    localparam logic [3:0] CMD_WRITE     = 4'h1;
    localparam logic [3:0] CMD_READ      = 4'h2;
    localparam logic [3:0] CMD_READ_NEXT = 4'h3;

    // Last wait count before the start cycle; only reachable when the
    // delay is non-zero, so the wrap for a zero delay is harmless.
    localparam logic [3:0] WAIT_LAST = 4'(RESPONSE_DELAY - 1);

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_STOP
    } rx_state_t;

    rx_state_t   rx_state, rx_state_next;
    logic [3:0]  rx_cnt, rx_cnt_next;
    logic [19:0] rx_sr, rx_sr_next;
    logic        stop_ok;
    logic        stop_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_sr    <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_sr    <= rx_sr_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_sr_next    = rx_sr;
        stop_ok       = 1'b0;
        stop_bad      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!link.rx_pins[0]) begin
                    rx_state_next = RX_SHIFT;
                    rx_cnt_next   = '0;
                end
            end
            RX_SHIFT: begin
                // New pairs enter at the top so the first payload cycle
                // ends up in bits [1:0] after ten shifts.
                rx_sr_next = {link.rx_pins, rx_sr[19:2]};
                if (rx_cnt == 4'd9) begin
                    rx_state_next = RX_STOP;
                end else begin
                    rx_cnt_next = rx_cnt + 4'd1;
                end
            end
            RX_STOP: begin
                rx_state_next = RX_IDLE;
                if (link.rx_pins == 2'b11) begin
                    stop_ok = 1'b1;
                end else begin
                    stop_bad = 1'b1;
                end
            end
            default: begin
                rx_state_next = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command execution (in the stop cycle of a good frame)
    // ------------------------------------------------------------------
    logic [3:0]           hdr;
    logic [15:0]          data;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS-1:0] addr_next;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [15:0]          resp_value;
    logic                 cmd_write;
    logic                 cmd_bad;
    logic                 resp_fire;
    logic [15:0]          mem [DEPTH];

    assign hdr  = rx_sr[3:0];
    assign data = rx_sr[19:4];

    always_comb begin
        addr_next = addr;
        cmd_write = 1'b0;
        cmd_bad   = 1'b0;
        resp_fire = 1'b0;
        rd_addr   = addr;
        if (stop_ok) begin
            case (hdr)
                CMD_SET_ADDR: begin
                    addr_next = data[ADDR_BITS-1:0];
                end
                CMD_WRITE: begin
                    cmd_write = 1'b1;
                    addr_next = addr + 1'b1;
                end
                CMD_READ: begin
                    resp_fire = 1'b1;
                    rd_addr   = data[ADDR_BITS-1:0];
                    addr_next = data[ADDR_BITS-1:0] + 1'b1;
                end
                CMD_READ_NEXT: begin
                    resp_fire = 1'b1;
                    addr_next = addr + 1'b1;
                end
                default: begin
                    cmd_bad = 1'b1;
                end
            endcase
        end
    end

    assign resp_value = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (cmd_write) begin
            mem[addr] <= data;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM and one-entry pending buffer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT,
        TX_FILL,
        TX_DATA
    } tx_state_t;

    tx_state_t   tx_state, tx_state_next;
    logic [3:0]  tx_cnt, tx_cnt_next;
    logic [15:0] tx_sr, tx_sr_next;
    logic [1:0]  tx_pins_q, tx_pins_next;
    logic        pend_valid, pend_valid_next;
    logic [15:0] pend_data, pend_data_next;
    logic        take;
    logic        take_buf;
    logic        bypass;
    logic        overrun_set;
    logic [15:0] take_data;
    logic        frame_error_q, bad_header_q, overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state      <= TX_IDLE;
            tx_cnt        <= '0;
            tx_sr         <= '0;
            tx_pins_q     <= 2'b11;
            pend_valid    <= 1'b0;
            pend_data     <= '0;
            addr          <= '0;
            frame_error_q <= 1'b0;
            bad_header_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            tx_state   <= tx_state_next;
            tx_cnt     <= tx_cnt_next;
            tx_sr      <= tx_sr_next;
            tx_pins_q  <= tx_pins_next;
            pend_valid <= pend_valid_next;
            pend_data  <= pend_data_next;
            addr       <= addr_next;
            if (stop_bad) begin
                frame_error_q <= 1'b1;
            end
            if (cmd_bad) begin
                bad_header_q <= 1'b1;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // A response executing while the transmitter is idle with no delay
    // bypasses the buffer so the start cycle follows the stop cycle
    // directly; a buffered entry always has priority over a fresh one.
    always_comb begin
        tx_state_next   = tx_state;
        tx_cnt_next     = tx_cnt;
        tx_sr_next      = tx_sr;
        tx_pins_next    = 2'b11;
        take            = 1'b0;
        take_data       = pend_valid ? pend_data : resp_value;
        case (tx_state)
            TX_IDLE: begin
                if (pend_valid || resp_fire) begin
                    if (RESPONSE_DELAY == 0) begin
                        take = 1'b1;
                    end else begin
                        tx_state_next = TX_WAIT;
                        tx_cnt_next   = '0;
                    end
                end
            end
            TX_WAIT: begin
                if (tx_cnt == WAIT_LAST) begin
                    take = 1'b1;
                end else begin
                    tx_cnt_next = tx_cnt + 4'd1;
                end
            end
            TX_FILL: begin
                if (tx_cnt == 4'd1) begin
                    tx_state_next = TX_DATA;
                    tx_cnt_next   = '0;
                end else begin
                    tx_cnt_next = tx_cnt + 4'd1;
                end
            end
            TX_DATA: begin
                tx_pins_next = tx_sr[1:0];
                tx_sr_next   = {2'b00, tx_sr[15:2]};
                if (tx_cnt == 4'd7) begin
                    tx_state_next = TX_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt + 4'd1;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
            end
        endcase
        if (take) begin
            tx_pins_next  = 2'b10;
            tx_sr_next    = take_data;
            tx_state_next = TX_FILL;
            tx_cnt_next   = '0;
        end
    end

    assign take_buf = take && pend_valid;
    assign bypass   = take && !pend_valid;

    always_comb begin
        pend_valid_next = pend_valid;
        pend_data_next  = pend_data;
        overrun_set     = 1'b0;
        if (take_buf) begin
            pend_valid_next = 1'b0;
        end
        if (resp_fire && !bypass) begin
            // The buffer counts as free in the cycle its entry is taken.
            if (pend_valid && !take_buf) begin
                overrun_set = 1'b1;
            end else begin
                pend_valid_next = 1'b1;
                pend_data_next  = resp_value;
            end
        end
    end

    assign link.tx_pins     = tx_pins_q;
    assign link.frame_error = frame_error_q;
    assign link.bad_header  = bad_header_q;
    assign link.overrun     = overrun_q;

endmodule
